// File: rtl/chunked_add_sub_if.sv
// rtl/chunked_add_sub_if.sv - command/result handshake bundle for chunked_add_sub
// Ports (master = requester, slave = chunked_add_sub):
//   in_valid/in_ready/op/a/b   : command channel, master -> slave
//   out_valid/out_ready        : result channel handshake, slave -> master
//   result/carryout/overflow/zero/finalB/bad_op : result payload, slave -> master
interface chunked_add_sub_if #(
   parameter int WIDTH = 32
);
   logic             in_valid;
   logic             in_ready;
   logic [2:0]       op;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] result;
   logic             carryout;
   logic             overflow;
   logic             zero;
   logic [WIDTH-1:0] finalB;
   logic             bad_op;

   modport master (
      output in_valid, op, a, b, out_ready,
      input  in_ready, out_valid, result, carryout, overflow, zero, finalB, bad_op
   );

   modport slave (
      input  in_valid, op, a, b, out_ready,
      output in_ready, out_valid, result, carryout, overflow, zero, finalB, bad_op
   );
endinterface

// File: rtl/chunked_add_sub.sv
// rtl/chunked_add_sub.sv - multi-cycle adder/subtracter processing CHUNK bits per clock
// Ports:
//   clk   : rising-edge clock
//   reset : synchronous active-high reset
//   bus   : chunked_add_sub_if.slave (command in, result + flags out)
// WIDTH must be an integer multiple of CHUNK. Latency is WIDTH/CHUNK cycles from
// the accept edge to out_valid.
module chunked_add_sub #(
   parameter int WIDTH = 32,
   parameter int CHUNK = 8
) (
   input  logic              clk,
   input  logic              reset,
   chunked_add_sub_if.slave  bus
);
   localparam int NCHUNK = WIDTH / CHUNK;
   localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

   localparam logic [2:0] OP_ADD = 3'b000;
   localparam logic [2:0] OP_SUB = 3'b001;
   localparam logic [2:0] OP_SLT = 3'b011;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t            state;
   state_t            state_next;

   // a_q is consumed low slice first by shifting right. b_q rotates instead, so
   // after NCHUNK slices it is back in its original position and doubles as the
   // finalB output register.
   logic [WIDTH-1:0]  a_q;
   logic [WIDTH-1:0]  b_q;
   logic [WIDTH-1:0]  result_q;
   logic [IDXW-1:0]   idx_q;
   logic              carry_q;
   logic              slt_q;
   logic              bad_op_q;
   logic              carryout_q;
   logic              overflow_q;
   logic              zero_q;

   logic              is_sub;
   logic              is_bad;
   logic              last;
   logic [CHUNK:0]    sum;
   logic              slice_cout;
   logic              slice_msb;
   logic              slice_ovf;
   logic              slt_bit;
   logic [WIDTH-1:0]  sum_ext;
   logic [WIDTH-1:0]  result_shift;
   logic [WIDTH-1:0]  b_rot;

   assign is_sub = (bus.op == OP_SUB) || (bus.op == OP_SLT);
   assign is_bad = (bus.op != OP_ADD) && (bus.op != OP_SUB) && (bus.op != OP_SLT);
   assign last   = (idx_q == IDXW'(NCHUNK - 1));

   always_comb begin
      sum        = {1'b0, a_q[CHUNK-1:0]} + {1'b0, b_q[CHUNK-1:0]} + {{CHUNK{1'b0}}, carry_q};
      slice_cout = sum[CHUNK];
      slice_msb  = sum[CHUNK-1];
      // Carry into the slice MSB recovered from its sum bit: s = a ^ b ^ cin.
      slice_ovf  = (a_q[CHUNK-1] ^ b_q[CHUNK-1] ^ slice_msb) ^ slice_cout;
      slt_bit    = slice_msb ^ slice_ovf;
      sum_ext    = '0;
      sum_ext[CHUNK-1:0] = sum[CHUNK-1:0];
      // New slice enters at the top; after NCHUNK shifts slice 0 sits at bit 0.
      result_shift = (result_q >> CHUNK) | (sum_ext << (WIDTH - CHUNK));
      b_rot        = (b_q >> CHUNK) | (b_q << (WIDTH - CHUNK));
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (bus.in_valid) state_next = RUN;
         RUN:     if (last)         state_next = DONE;
         DONE:    if (bus.out_ready) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         a_q        <= '0;
         b_q        <= '0;
         result_q   <= '0;
         idx_q      <= '0;
         carry_q    <= 1'b0;
         slt_q      <= 1'b0;
         bad_op_q   <= 1'b0;
         carryout_q <= 1'b0;
         overflow_q <= 1'b0;
         zero_q     <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.in_valid) begin
                  a_q      <= bus.a;
                  b_q      <= is_sub ? ~bus.b : bus.b;
                  carry_q  <= is_sub;
                  slt_q    <= (bus.op == OP_SLT);
                  bad_op_q <= is_bad;
                  idx_q    <= '0;
               end
            end
            RUN: begin
               a_q     <= a_q >> CHUNK;
               b_q     <= b_rot;
               carry_q <= slice_cout;
               idx_q   <= idx_q + 1'b1;
               if (last && slt_q) begin
                  result_q   <= WIDTH'(slt_bit);
                  carryout_q <= 1'b0;
                  overflow_q <= 1'b0;
                  zero_q     <= ~slt_bit;
               end else if (last) begin
                  result_q   <= result_shift;
                  carryout_q <= slice_cout;
                  overflow_q <= slice_ovf;
                  zero_q     <= (result_shift == '0);
               end else begin
                  result_q   <= result_shift;
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.in_ready  = (state == IDLE);
   assign bus.out_valid = (state == DONE);
   assign bus.result    = result_q;
   assign bus.carryout  = carryout_q;
   assign bus.overflow  = overflow_q;
   assign bus.zero      = zero_q;
   assign bus.finalB    = b_q;
   assign bus.bad_op    = bad_op_q;
endmodule

// File: tb/tb_chunked_add_sub.sv
// tb/tb_chunked_add_sub.sv - directed vector bench for chunked_add_sub
module tb_chunked_add_sub;
   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   chunked_add_sub_if #(.WIDTH(32)) bus0 ();
   chunked_add_sub_if #(.WIDTH(16)) bus1 ();
   chunked_add_sub_if #(.WIDTH(32)) bus2 ();

   chunked_add_sub #(.WIDTH(32), .CHUNK(8))  u_dut0 (.clk(clk), .reset(reset), .bus(bus0));
   chunked_add_sub #(.WIDTH(16), .CHUNK(4))  u_dut1 (.clk(clk), .reset(reset), .bus(bus1));
   chunked_add_sub #(.WIDTH(32), .CHUNK(32)) u_dut2 (.clk(clk), .reset(reset), .bus(bus2));

   typedef struct {
      string       name;
      logic [2:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] r;
      logic        co;
      logic        ov;
      logic        z;
      logic [31:0] fb;
      logic        bad;
   } vec_t;

   typedef struct {
      logic        in_ready;
      logic        out_valid;
      logic [31:0] result;
      logic        carryout;
      logic        overflow;
      logic        zero;
      logic [31:0] finalB;
      logic        bad_op;
   } obs_t;

   int tests = 0;
   int fails = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(input string name, input logic [2:0] op, input logic [31:0] a,
                               input logic [31:0] b, input logic [31:0] r, input logic co,
                               input logic ov, input logic z, input logic [31:0] fb, input logic bad);
      vec_t v;
      v.name = name; v.op = op; v.a = a; v.b = b; v.r = r;
      v.co = co; v.ov = ov; v.z = z; v.fb = fb; v.bad = bad;
      return v;
   endfunction

   task automatic drive(input int sel, input logic v, input logic [2:0] op,
                        input logic [31:0] a, input logic [31:0] b, input logic ordy);
      case (sel)
         0: begin bus0.in_valid = v; bus0.op = op; bus0.a = a; bus0.b = b; bus0.out_ready = ordy; end
         1: begin bus1.in_valid = v; bus1.op = op; bus1.a = a[15:0]; bus1.b = b[15:0]; bus1.out_ready = ordy; end
         default: begin bus2.in_valid = v; bus2.op = op; bus2.a = a; bus2.b = b; bus2.out_ready = ordy; end
      endcase
   endtask

   function automatic obs_t sample(input int sel);
      obs_t o;
      case (sel)
         0: begin
            o.in_ready = bus0.in_ready; o.out_valid = bus0.out_valid; o.result = bus0.result;
            o.carryout = bus0.carryout; o.overflow = bus0.overflow; o.zero = bus0.zero;
            o.finalB = bus0.finalB; o.bad_op = bus0.bad_op;
         end
         1: begin
            o.in_ready = bus1.in_ready; o.out_valid = bus1.out_valid; o.result = {16'h0, bus1.result};
            o.carryout = bus1.carryout; o.overflow = bus1.overflow; o.zero = bus1.zero;
            o.finalB = {16'h0, bus1.finalB}; o.bad_op = bus1.bad_op;
         end
         default: begin
            o.in_ready = bus2.in_ready; o.out_valid = bus2.out_valid; o.result = bus2.result;
            o.carryout = bus2.carryout; o.overflow = bus2.overflow; o.zero = bus2.zero;
            o.finalB = bus2.finalB; o.bad_op = bus2.bad_op;
         end
      endcase
      return o;
   endfunction

   // Offer one command, scramble the inputs after the accept edge, wait for the
   // result (bounded), capture it, then consume it. lat counts cycles from the
   // accept edge to the first cycle with out_valid.
   task automatic run_op(input int sel, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, output obs_t o, output int lat);
      @(negedge clk);
      drive(sel, 1'b1, op, a, b, 1'b0);
      @(negedge clk);
      drive(sel, 1'b0, 3'b111, ~a, 32'hA5A5_5A5A, 1'b0);
      lat = 0;
      while (!sample(sel).out_valid && lat < 20) begin
         @(negedge clk);
         lat++;
      end
      o = sample(sel);
      drive(sel, 1'b0, 3'b000, 32'h0, 32'h0, 1'b1);
      @(negedge clk);
      drive(sel, 1'b0, 3'b000, 32'h0, 32'h0, 1'b0);
   endtask

   localparam int NV = 12;
   vec_t vecs [NV];

   initial begin
      #200000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1);
   end

   initial begin
      obs_t o;
      int   lat;

      vecs[0]  = mk("add_zero",   3'b000, 32'h00000000, 32'h00000000, 32'h00000000, 0, 0, 1, 32'h00000000, 0);
      vecs[1]  = mk("add_carry8", 3'b000, 32'h000000FF, 32'h00000001, 32'h00000100, 0, 0, 0, 32'h00000001, 0);
      vecs[2]  = mk("add_wrap",   3'b000, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1, 0, 1, 32'h00000001, 0);
      vecs[3]  = mk("add_ovf",    3'b000, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 0, 1, 0, 32'h00000001, 0);
      vecs[4]  = mk("add_ovfco",  3'b000, 32'h80210000, 32'h80010080, 32'h00220080, 1, 1, 0, 32'h80010080, 0);
      vecs[5]  = mk("sub_5_3",    3'b001, 32'h00000005, 32'h00000003, 32'h00000002, 1, 0, 0, 32'hFFFFFFFC, 0);
      vecs[6]  = mk("sub_3_5",    3'b001, 32'h00000003, 32'h00000005, 32'hFFFFFFFE, 0, 0, 0, 32'hFFFFFFFA, 0);
      vecs[7]  = mk("sub_ovf",    3'b001, 32'h80000000, 32'h00000001, 32'h7FFFFFFF, 1, 1, 0, 32'hFFFFFFFE, 0);
      vecs[8]  = mk("slt_m1_1",   3'b011, 32'hFFFFFFFF, 32'h00000001, 32'h00000001, 0, 0, 0, 32'hFFFFFFFE, 0);
      vecs[9]  = mk("slt_1_m1",   3'b011, 32'h00000001, 32'hFFFFFFFF, 32'h00000000, 0, 0, 1, 32'h00000000, 0);
      vecs[10] = mk("slt_max_min",3'b011, 32'h7FFFFFFF, 32'h80000000, 32'h00000000, 0, 0, 1, 32'h7FFFFFFF, 0);
      vecs[11] = mk("bad_op",     3'b110, 32'h00001234, 32'h00000010, 32'h00001244, 0, 0, 0, 32'h00000010, 1);

      reset = 1'b1;
      for (int s = 0; s < 3; s++) drive(s, 1'b0, 3'b000, 32'h0, 32'h0, 1'b0);
      repeat (3) @(negedge clk);
      o = sample(0);
      check("rst_in_ready",  o.in_ready,  1'b1);
      check("rst_out_valid", o.out_valid, 1'b0);
      check("rst_result",    o.result,    32'h0);
      check("rst_flags",     {o.carryout, o.overflow, o.zero, o.bad_op}, 4'b0000);
      check("rst_finalB",    o.finalB,    32'h0);
      reset = 1'b0;

      for (int i = 0; i < NV; i++) begin
         run_op(0, vecs[i].op, vecs[i].a, vecs[i].b, o, lat);
         check({vecs[i].name, "_lat"},      lat,        4);
         check({vecs[i].name, "_result"},   o.result,   vecs[i].r);
         check({vecs[i].name, "_carryout"}, o.carryout, vecs[i].co);
         check({vecs[i].name, "_overflow"}, o.overflow, vecs[i].ov);
         check({vecs[i].name, "_zero"},     o.zero,     vecs[i].z);
         check({vecs[i].name, "_finalB"},   o.finalB,   vecs[i].fb);
         check({vecs[i].name, "_bad_op"},   o.bad_op,   vecs[i].bad);
      end

      // Result held in DONE with out_ready low while a new command is offered.
      @(negedge clk);
      drive(0, 1'b1, 3'b000, 32'h7FFFFFFF, 32'h00000001, 1'b0);
      @(negedge clk);
      drive(0, 1'b0, 3'b000, 32'h0, 32'h0, 1'b0);
      lat = 0;
      while (!bus0.out_valid && lat < 20) begin
         @(negedge clk);
         lat++;
      end
      check("hold_lat", lat, 4);
      for (int c = 0; c < 3; c++) begin
         drive(0, 1'b1, 3'b001, 32'h12345678, 32'h00000009, 1'b0);
         @(negedge clk);
         o = sample(0);
         check("hold_out_valid", o.out_valid, 1'b1);
         check("hold_in_ready",  o.in_ready,  1'b0);
         check("hold_result",    o.result,    32'h80000000);
         check("hold_flags",     {o.carryout, o.overflow, o.zero}, 3'b010);
         check("hold_finalB",    o.finalB,    32'h00000001);
      end
      drive(0, 1'b0, 3'b000, 32'h0, 32'h0, 1'b1);
      @(negedge clk);
      drive(0, 1'b0, 3'b000, 32'h0, 32'h0, 1'b0);
      o = sample(0);
      check("consume_out_valid", o.out_valid, 1'b0);
      check("consume_in_ready",  o.in_ready,  1'b1);

      // Reset during the second RUN cycle discards the operation.
      @(negedge clk);
      drive(0, 1'b1, 3'b001, 32'h0F0F0F0F, 32'h01010101, 1'b0);
      @(negedge clk);
      drive(0, 1'b0, 3'b000, 32'h0, 32'h0, 1'b0);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      o = sample(0);
      check("midrst_in_ready",  o.in_ready,  1'b1);
      check("midrst_out_valid", o.out_valid, 1'b0);
      check("midrst_result",    o.result,    32'h0);
      check("midrst_flags",     {o.carryout, o.overflow, o.zero, o.bad_op}, 4'b0000);
      check("midrst_finalB",    o.finalB,    32'h0);

      run_op(0, 3'b000, 32'h000000FF, 32'h00000001, o, lat);
      check("post_rst_lat",    lat,      4);
      check("post_rst_result", o.result, 32'h00000100);

      // Other geometries.
      run_op(1, 3'b000, 32'h00007FFF, 32'h00000001, o, lat);
      check("w16c4_lat",      lat,        4);
      check("w16c4_result",   o.result,   32'h00008000);
      check("w16c4_overflow", o.overflow, 1'b1);
      check("w16c4_carryout", o.carryout, 1'b0);
      check("w16c4_zero",     o.zero,     1'b0);

      run_op(2, 3'b000, 32'h7FFFFFFF, 32'h00000001, o, lat);
      check("w32c32_lat",      lat,        1);
      check("w32c32_result",   o.result,   32'h80000000);
      check("w32c32_overflow", o.overflow, 1'b1);
      check("w32c32_carryout", o.carryout, 1'b0);

      run_op(2, 3'b011, 32'hFFFFFFFF, 32'h00000001, o, lat);
      check("w32c32_slt_result", o.result, 32'h00000001);
      check("w32c32_slt_finalB", o.finalB, 32'hFFFFFFFE);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/chunked_add_sub.md
# chunked_add_sub

Parametrised, multi-cycle adder/subtracter for the ALU datapath. It processes a WIDTH-bit operation in CHUNK-bit slices, one slice per clock, and carries between slices in a register. This trades latency for a short carry chain. Operands are accepted, and results returned, through valid/ready handshakes. The flag set matches the 32-bit combinational adder_subtracter: carryout, overflow, and the effective B operand, with zero added.

## Interface
- WIDTH, 32, operand/result width; must be an integer multiple of CHUNK.
- CHUNK, 8, bits processed per cycle; NCHUNK = WIDTH/CHUNK; CHUNK = WIDTH gives single-slice operation.
- clk  input  1  sole clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  operand/command offered.
- in_ready  output  1  block can accept a command; high only in IDLE.
- op  input  3  command: 3'b000 ADD, 3'b001 SUB, 3'b011 SLT; all other codes execute as ADD and set bad_op.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- out_valid  output  1  result registers hold a completed operation.
- out_ready  input  1  consumer accepts the result.
- result  output  WIDTH  sum, difference, or SLT flag in bit 0.
- carryout  output  1  carry out of the MSB.
- overflow  output  1  signed overflow.
- zero  output  1  result == 0.
- finalB  output  WIDTH  effective B fed to the adder: b for ADD, ~b for SUB/SLT.
- bad_op  output  1  op was not a defined code.

## Operation
- States: IDLE, RUN, DONE.
- IDLE: in_ready = 1.
  - On in_valid & in_ready, latch a, finalB, op, and bad_op.
  - Set carry register to 1 for SUB/SLT, 0 otherwise.
  - Set chunk index to 0 and go to RUN.
- RUN: each cycle, add slice i of A, slice i of finalB, and the carry register.
  - Write the slice into the result register.
  - Update the carry register and increment the index.
  - When i = NCHUNK-1, also compute carryout and overflow, then go to DONE.
- Overflow is defined as carry into MSB XOR carry out of MSB. It is computed from the final slice only.
- SLT: result = {WIDTH-1 zeros, diff[WIDTH-1] XOR overflow}; carryout and overflow are then forced to 0.
- zero is evaluated on the final result value, so for SLT it refers to the SLT output.
- DONE: out_valid = 1, and result and all flags are stable. On out_ready, go to IDLE.
- A new command cannot be accepted in the cycle the result is consumed; in_ready rises the following cycle.
- Reset, at any point including mid-RUN or in DONE:
  - State returns to IDLE and any partial operation is discarded.
  - All outputs read 0, except in_ready = 1.
- in_valid is ignored outside IDLE. Input values are not sampled after the accept edge and may change freely.

## Timing
- Accept edge = edge T at which in_valid & in_ready are both high.
- Slice i is computed on edge T+1+i.
- out_valid is high in the cycle after edge T+NCHUNK, i.e. NCHUNK cycles after the accept edge (4 cycles for defaults, 1 cycle for CHUNK = WIDTH).
- out_valid holds, with result and flags unchanged, for as long as out_ready is low.
- Throughput is one operation per NCHUNK+2 cycles when out_ready is held high.
- result bits may be observed changing during RUN. They are only defined while out_valid = 1.
- All outputs are registered; no combinational path from inputs to outputs, except in_ready, which is decoded from state.

## Test plan
- ADD a = 0x00000000, b = 0x00000000 -> result 0, zero 1, carryout 0, overflow 0, finalB 0, out_valid exactly 4 cycles after accept.
- Cross-slice carry: ADD 0x000000FF + 0x00000001 -> 0x00000100. Then ADD 0xFFFFFFFF + 0x00000001 -> 0x00000000, carryout 1, overflow 0, zero 1.
- Overflow:
  - ADD 0x7FFFFFFF + 0x00000001 -> 0x80000000, overflow 1, carryout 0.
  - ADD 0x80210000 + 0x80010080 -> 0x00220080, carryout 1, overflow 1.
- SUB 5 - 3 -> 2, carryout 1, finalB 0xFFFFFFFC.
- SLT:
  - SLT a = 0xFFFFFFFF, b = 1 -> result 1.
  - SLT 1, 0xFFFFFFFF -> result 0, zero 1.
  - SLT 0x7FFFFFFF, 0x80000000 -> 0.
  - op = 3'b110 -> executes as ADD, bad_op 1.
- Handshake and reset:
  - Hold out_ready low 3 cycles in DONE: result and flags stay stable, in_valid is ignored.
  - Assert reset on the 2nd RUN cycle: the next cycle shows IDLE, in_ready 1, out_valid 0, and outputs 0.
  - Repeat the 0x7FFFFFFF + 1 case with WIDTH = 16, CHUNK = 4 and WIDTH = 32, CHUNK = 32, scaling operands to 0x7FFF + 1 for the 16-bit build.
